// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM duty generator.
// Holds the FSM encoding, the shortest runnable period and the duty clamp.
package pwm_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pwm_state_e;

  // Periods below this cannot hold both a high and a low phase, so they park the FSM.
  localparam int MIN_PERIOD = 2;

  // Width of the stability counter; covers STABLE_CYCLES up to 255.
  localparam int STAB_W = 8;

  // Duty at or above the period (including bits above the counter width) saturates
  // to the period, which the comparator turns into a constant-high output.
  function automatic logic [63:0] clamp_duty(input logic [63:0] duty,
                                             input logic [63:0] period);
    return (duty >= period) ? period : duty;
  endfunction

endpackage

// File: rtl/pwm_duty_gen_pair_qualifier.sv
// Waits for cycle/duty to sit unchanged for STABLE_CYCLES clocks, then latches the pair
// as pending (if it differs from the active pair); no backpressure, newest pair wins.
module pair_qualifier
  import pwm_pkg::*;
#(
  parameter int CW            = 28,
  parameter int DW            = 32,
  parameter int STABLE_CYCLES = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [CW-1:0] cycle_i,
  input  logic [DW-1:0] duty_i,
  input  logic [CW-1:0] act_cycle_i,
  input  logic [DW-1:0] act_duty_i,
  input  logic          pend_clr_i,
  output logic          pend_valid,
  output logic [CW-1:0] pend_cycle,
  output logic [DW-1:0] pend_duty
);

  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

  logic [CW-1:0]     prev_cycle_q;
  logic [DW-1:0]     prev_duty_q;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic              pend_valid_q, pend_valid_d;
  logic [CW-1:0]     pend_cycle_q, pend_cycle_d;
  logic [DW-1:0]     pend_duty_q, pend_duty_d;
  logic              changed;
  logic              reach;
  logic              capture;

  always_comb begin
    changed = (cycle_i != prev_cycle_q) || (duty_i != prev_duty_q);
    reach   = !changed && (stab_q == STAB_LAST);
    capture = reach && ((cycle_i != act_cycle_i) || (duty_i != act_duty_i));

    stab_d = stab_q;
    if (changed) begin
      stab_d = '0;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + STAB_W'(1);
    end

    // A capture on the same edge as a load must survive the clear: it is a newer pair.
    pend_valid_d = pend_valid_q;
    pend_cycle_d = pend_cycle_q;
    pend_duty_d  = pend_duty_q;
    if (capture) begin
      pend_valid_d = 1'b1;
      pend_cycle_d = cycle_i;
      pend_duty_d  = duty_i;
    end else if (pend_clr_i) begin
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_cycle_q <= '0;
      prev_duty_q  <= '0;
      stab_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_cycle_q <= '0;
      pend_duty_q  <= '0;
    end else begin
      prev_cycle_q <= cycle_i;
      prev_duty_q  <= duty_i;
      stab_q       <= stab_d;
      pend_valid_q <= pend_valid_d;
      pend_cycle_q <= pend_cycle_d;
      pend_duty_q  <= pend_duty_d;
    end
  end

  assign pend_valid = pend_valid_q;
  assign pend_cycle = pend_cycle_q;
  assign pend_duty  = pend_duty_q;

endmodule

// File: rtl/pwm_duty_gen.sv
// Glitch-free PWM generator; qualified period/duty pairs apply only at period boundaries.
// Latency: capture STABLE_CYCLES+1 clocks after an input change, output within a period+1.
module pwm_duty_gen
  import pwm_pkg::*;
#(
  parameter int CW            = 28,
  parameter int DW            = 32,
  parameter int STABLE_CYCLES = 16
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic [CW-1:0] cycle_in,
  input  logic [DW-1:0] duty_in,
  output logic          pwm_out,
  output logic          period_start,
  output logic          update_pending,
  output logic [CW-1:0] active_period
);

  pwm_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] act_cycle_q, act_cycle_d;
  logic [DW-1:0] act_duty_q, act_duty_d;
  logic          pwm_q, pwm_d;
  logic          ps_q, ps_d;

  logic          pend_valid;
  logic [CW-1:0] pend_cycle;
  logic [DW-1:0] pend_duty;
  logic          pend_clr;
  logic [CW-1:0] duty_eff;
  logic          last_cnt;
  logic          pend_runnable;

  pair_qualifier #(
    .CW            (CW),
    .DW            (DW),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_qual (
    .clk_i       (clk_clk),
    .rst_ni      (reset_reset_n),
    .cycle_i     (cycle_in),
    .duty_i      (duty_in),
    .act_cycle_i (act_cycle_q),
    .act_duty_i  (act_duty_q),
    .pend_clr_i  (pend_clr),
    .pend_valid  (pend_valid),
    .pend_cycle  (pend_cycle),
    .pend_duty   (pend_duty)
  );

  always_comb begin
    duty_eff      = CW'(clamp_duty(64'(act_duty_q), 64'(act_cycle_q)));
    last_cnt      = (cnt_q == act_cycle_q - CW'(1));
    pend_runnable = (pend_cycle >= CW'(MIN_PERIOD));

    state_d     = state_q;
    cnt_d       = cnt_q;
    act_cycle_d = act_cycle_q;
    act_duty_d  = act_duty_q;
    pend_clr    = 1'b0;
    ps_d        = 1'b0;
    // Compare uses the pre-edge pair, so a swap at the wrap never shortens the last sample.
    pwm_d       = (state_q == ST_RUN) && (cnt_q < duty_eff);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pend_valid) begin
          act_cycle_d = pend_cycle;
          act_duty_d  = pend_duty;
          pend_clr    = 1'b1;
          if (pend_runnable) begin
            state_d = ST_RUN;
            ps_d    = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (last_cnt) begin
          cnt_d = '0;
          ps_d  = 1'b1;
          if (pend_valid) begin
            act_cycle_d = pend_cycle;
            act_duty_d  = pend_duty;
            pend_clr    = 1'b1;
            if (!pend_runnable) begin
              state_d = ST_IDLE;
              ps_d    = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      act_cycle_q <= '0;
      act_duty_q  <= '0;
      pwm_q       <= 1'b0;
      ps_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_cycle_q <= act_cycle_d;
      act_duty_q  <= act_duty_d;
      pwm_q       <= pwm_d;
      ps_q        <= ps_d;
    end
  end

  assign pwm_out        = pwm_q;
  assign period_start   = ps_q;
  assign update_pending = pend_valid;
  assign active_period  = act_cycle_q;

endmodule

// File: tb/tb_pwm_duty_gen.sv
// Bench for pwm_duty_gen: table-driven phases, hand-written corner sequences and a
// randomized run, all compared cycle by cycle against an edge-indexed reference model.
module tb_pwm_duty_gen;

  localparam int CW = 28;
  localparam int DW = 32;
  localparam int S  = 16;

  logic          clk_clk = 1'b0;
  logic          reset_reset_n;
  logic [CW-1:0] cycle_in;
  logic [DW-1:0] duty_in;
  logic          pwm_out;
  logic          period_start;
  logic          update_pending;
  logic [CW-1:0] active_period;

  int errors = 0;
  int checks = 0;

  always #5 clk_clk = ~clk_clk;

  pwm_duty_gen #(
    .CW            (CW),
    .DW            (DW),
    .STABLE_CYCLES (S)
  ) dut (
    .clk_clk        (clk_clk),
    .reset_reset_n  (reset_reset_n),
    .cycle_in       (cycle_in),
    .duty_in        (duty_in),
    .pwm_out        (pwm_out),
    .period_start   (period_start),
    .update_pending (update_pending),
    .active_period  (active_period)
  );

  // Reference model, expressed in edge indices: k counts clock edges, s_edge is the
  // edge on which the running period began, since is the edge the inputs last changed.
  longint      k = 0;
  longint      s_edge = 0;
  longint      since = 0;
  logic [63:0] last_c, last_d;
  logic        m_run, m_pv, m_pwm, m_ps;
  logic [63:0] m_ac, m_ad, m_pc, m_pd;

  task automatic model_edge(input logic rst_n, input logic [63:0] c, input logic [63:0] d);
    logic [63:0] pos, eff, old_c, old_d;
    logic        bnd, go;
    k++;
    if (!rst_n) begin
      m_run = 0; m_pv = 0; m_pwm = 0; m_ps = 0;
      m_ac = 0; m_ad = 0; m_pc = 0; m_pd = 0;
      since = k; last_c = 0; last_d = 0;
      return;
    end
    pos   = 64'(k - 1 - s_edge);
    eff   = (m_ad >= m_ac) ? m_ac : m_ad;
    m_pwm = m_run && (pos < eff);
    bnd   = m_run && (pos + 1 == m_ac);
    go    = !m_run && m_pv;
    old_c = m_ac;
    old_d = m_ad;
    m_ps  = 0;
    if ((bnd && m_pv) || go) begin
      m_ac = m_pc; m_ad = m_pd; m_pv = 0;
    end
    if (bnd || go) begin
      if (m_ac >= 2) begin
        m_run = 1; s_edge = k; m_ps = 1;
      end else begin
        m_run = 0;
      end
    end
    if (c != last_c || d != last_d) begin
      since = k; last_c = c; last_d = d;
    end
    if ((k - since == S) && (c != old_c || d != old_d)) begin
      m_pc = c; m_pd = d; m_pv = 1;
    end
  endtask

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", name, k, got, exp);
    end
  endfunction

  task automatic step(input logic [CW-1:0] c, input logic [DW-1:0] d, input logic rst_n);
    cycle_in      = c;
    duty_in       = d;
    reset_reset_n = rst_n;
    @(posedge clk_clk);
    model_edge(rst_n, 64'(c), 64'(d));
    #1;
    chk("pwm_out", 64'(pwm_out), 64'(m_pwm));
    chk("period_start", 64'(period_start), 64'(m_ps));
    chk("update_pending", 64'(update_pending), 64'(m_pv));
    chk("active_period", 64'(active_period), m_ac);
  endtask

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    int            hold;
    logic [CW-1:0] exp_act;
    logic          exp_pend;
    int            pwm_mode;  // 0 any, 1 constant low, 2 constant high over last 16
    int            ps16;      // period_start pulses in last 16 cycles, -1 any
  } vec_t;

  vec_t vec[7];
  int   hi, ps, n, seen, dropped, found, hold;
  logic [CW-1:0] rc;
  logic [DW-1:0] rd;

  initial begin
    vec[0] = '{c: 10, d: 3,            hold: 40, exp_act: 10, exp_pend: 0, pwm_mode: 0, ps16: -1};
    vec[1] = '{c: 20, d: 3,            hold: 4,  exp_act: 10, exp_pend: 0, pwm_mode: 0, ps16: -1};
    vec[2] = '{c: 20, d: 5,            hold: 60, exp_act: 20, exp_pend: 0, pwm_mode: 0, ps16: -1};
    vec[3] = '{c: 8,  d: 0,            hold: 60, exp_act: 8,  exp_pend: 0, pwm_mode: 1, ps16: 2};
    vec[4] = '{c: 8,  d: 32'hFFFF_FFFF, hold: 60, exp_act: 8,  exp_pend: 0, pwm_mode: 2, ps16: 2};
    vec[5] = '{c: 1,  d: 32'hFFFF_FFFF, hold: 60, exp_act: 1,  exp_pend: 0, pwm_mode: 1, ps16: 0};
    vec[6] = '{c: 6,  d: 2,            hold: 60, exp_act: 6,  exp_pend: 0, pwm_mode: 0, ps16: -1};

    for (int i = 0; i < 3; i++) step('0, '0, 1'b0);

    for (int v = 0; v < 7; v++) begin
      hi = 0;
      ps = 0;
      for (int i = 0; i < vec[v].hold; i++) begin
        step(vec[v].c, vec[v].d, 1'b1);
        if (i >= vec[v].hold - 16) begin
          hi += int'(pwm_out);
          ps += int'(period_start);
        end
      end
      chk("tbl_active", 64'(active_period), 64'(vec[v].exp_act));
      chk("tbl_pending", 64'(update_pending), 64'(vec[v].exp_pend));
      if (vec[v].pwm_mode == 1) chk("tbl_const_low", 64'(hi), 64'd0);
      if (vec[v].pwm_mode == 2) chk("tbl_const_high", 64'(hi), 64'd16);
      if (vec[v].ps16 >= 0) chk("tbl_ps_count", 64'(ps), 64'(vec[v].ps16));
    end

    // Split write: period first, duty 4 clocks later; only the final pair may apply.
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(12, 2, 1'b1);
      seen += int'(update_pending);
    end
    chk("no_intermediate_pair", 64'(seen), 64'd0);
    n = 0;
    while (n < 40) begin
      step(12, 5, 1'b1);
      n++;
      if (update_pending) break;
    end
    chk("qualify_latency", 64'(n), 64'd17);
    dropped = 0;
    found   = 0;
    for (int i = 0; i < 12; i++) begin
      step(12, 5, 1'b1);
      if (period_start) begin
        found = 1;
        break;
      end
      if (!update_pending || active_period != 6) dropped++;
    end
    chk("load_seen", 64'(found), 64'd1);
    chk("pending_held_until_wrap", 64'(dropped), 64'd0);
    chk("load_active", 64'(active_period), 64'd12);
    chk("load_pending_clear", 64'(update_pending), 64'd0);

    // Duty toggling faster than the qualifier window must never reach the output.
    seen = 0;
    hi   = 0;
    for (int i = 0; i < 60; i++) begin
      step(12, ((i / 3) % 2 == 1) ? 32'd7 : 32'd5, 1'b1);
      seen += int'(update_pending);
      if (i >= 48) hi += int'(pwm_out);
    end
    chk("toggle_no_pending", 64'(seen), 64'd0);
    chk("toggle_active", 64'(active_period), 64'd12);
    chk("toggle_old_duty", 64'(hi), 64'd5);

    // Reset in the middle of a high pulse.
    found = 0;
    for (int i = 0; i < 30; i++) begin
      step(12, 5, 1'b1);
      if (pwm_out) begin
        found = 1;
        break;
      end
    end
    chk("high_pulse_found", 64'(found), 64'd1);
    step(12, 5, 1'b0);
    chk("rst_pwm", 64'(pwm_out), 64'd0);
    chk("rst_period_start", 64'(period_start), 64'd0);
    chk("rst_pending", 64'(update_pending), 64'd0);
    chk("rst_active", 64'(active_period), 64'd0);
    n  = 0;
    hi = 0;
    while (n < 40) begin
      step(12, 5, 1'b1);
      n++;
      if (period_start) break;
      hi += int'(pwm_out);
    end
    chk("requalify_restart", 64'(n), 64'd18);
    chk("requalify_low", 64'(hi), 64'd0);

    // Randomized segments with occasional reset pulses.
    for (int seg = 0; seg < 80; seg++) begin
      rc   = CW'($urandom_range(0, 12));
      rd   = ($urandom_range(0, 5) == 0) ? DW'($urandom) : DW'($urandom_range(0, 14));
      hold = int'($urandom_range(1, 40));
      for (int i = 0; i < hold; i++) begin
        step(rc, rd, ($urandom_range(0, 199) != 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_duty_gen.md
Name: pwm_duty_gen

Overview:
- Downstream PWM stage driven by the Nios II soft system's 28-bit cycle PIO and 32-bit duty PIO.
- Produces one glitch-free PWM output for a servo or ESC.
- The two PIOs are written by separate bus cycles, so a period/duty pair is applied only after both are stable for a qualification time.
- A new pair takes effect only at a period boundary, so no runt or over-long pulses are ever emitted.

Parameters:
- CW, 28, width of period input and counters.
- DW, 32, width of duty input.
- STABLE_CYCLES, 16, consecutive unchanged cycles required before a period/duty pair is captured (range 1..255).

Ports:
- clk_clk  input  1  system clock (same clock as the Nios II system).
- reset_reset_n  input  1  reset; synchronous, active-low.
- cycle_in  input  CW  requested period in clocks (from cycle PIO).
- duty_in  input  DW  requested high time in clocks (from duty PIO).
- pwm_out  output  1  registered PWM output.
- period_start  output  1  one-cycle pulse on the first clock of each active period.
- update_pending  output  1  high while a qualified pair waits for the next boundary.
- active_period  output  CW  period currently being generated (readback).

Behaviour:
- Reset (reset_reset_n=0 at a clk_clk edge):
  - pwm_out=0, period_start=0, update_pending=0, active_period=0.
  - Counter=0, stability counter=0, shadow registers=0.
  - State=IDLE.
  - Reset asserted mid-period truncates the pulse immediately at the next edge.
- Stability qualifier:
  - Registers the previous cycle_in and duty_in.
  - If either input differs from its registered copy, the stability counter clears to 0.
  - Otherwise the counter increments, saturating at STABLE_CYCLES.
  - On the cycle the count reaches STABLE_CYCLES, the pair is written to the pending registers if it differs from the active pair. update_pending then sets.
  - A pending pair may be overwritten by a newer qualified pair before it is applied; the last one wins.
- Duty width rule:
  - Effective duty = duty_in clamped to period.
  - Any duty_in >= period (including bits above CW) means constant high for that period.
- States:
  - IDLE:
    - pwm_out=0, counter held at 0.
    - Entered from reset or when an applied period is 0 or 1.
    - Leaves when update_pending=1 and the pending period >= 2: the pair loads on the next edge, the state goes to RUN, the counter goes to 0 and period_start pulses.
  - RUN:
    - Counter counts 0..period-1.
    - pwm_out is registered as (counter < duty_act), so the output lags the counter by 1 cycle.
    - On the last count (counter==period-1), if update_pending: the pending pair loads into the active pair and update_pending clears, on the same edge as the counter wraps to 0.
    - If the loaded period is < 2, the state goes to IDLE instead (the wrap still occurs).
    - Otherwise period_start pulses in the wrap cycle.
- Boundary cases:
  - duty=0 gives constant low.
  - duty >= period gives constant high, with no low glitch at the wrap.
  - A new pair qualifying on the same cycle as the wrap is not applied on that wrap; it waits for the next boundary.
  - Input changes during the wait never alter the current period.
- Latency:
  - Input change to capture: STABLE_CYCLES+1 clocks.
  - Capture to output: up to one full period + 1 clock.

Decomposition:
- Shared package pwm_pkg:
  - State enum (IDLE, RUN).
  - Constant MIN_PERIOD=2.
  - Clamp function for duty against period.
- Sub-module pair_qualifier contains the stability counter, previous-value registers and pending registers. It outputs pend_valid, pend_cycle and pend_duty.
- The top level contains the FSM, period counter and output register.

Test Plan:
- Reset, then cycle_in=10, duty_in=3 held steady. Required response after STABLE_CYCLES+1 clocks:
  - period_start pulses.
  - pwm_out shows 3 high / 7 low, repeating every 10 clocks.
  - active_period=10.
- While running 10/3, write cycle_in=20, wait 4 clocks, then write duty_in=5. Required response:
  - No intermediate 20/3 period is ever generated.
  - 20/5 appears at the first boundary after qualification.
  - update_pending is high until that wrap.
- Apply duty_in=0, then duty_in=32'hFFFF_FFFF with period=8. Required response:
  - pwm_out stays constant low, then constant high.
  - pwm_out does not glitch at the wraps.
  - period_start still pulses every 8 clocks.
- Apply cycle_in=1 while running. Required response:
  - At the next boundary the state goes to IDLE and pwm_out=0.
  - Then apply cycle_in=6, duty_in=2: RUN restarts with period_start.
- Toggle duty_in every 3 clocks with STABLE_CYCLES=16. Required response:
  - update_pending never sets.
  - The output keeps the old pair.
- Assert reset_reset_n=0 for 1 cycle mid-high-pulse. Required response:
  - pwm_out=0 at the next edge.
  - All outputs are at their reset values.
  - Restart happens only after re-qualification.
